// File: rtl/x_rr_arbiter_hs.sv
// Round-robin row arbiter with a valid/ready grant handshake and burst hold.
// One registered stage sits between req_i and the grant outputs; ready_i only
// steers next-state logic. After an accepted beat the priority pointer moves
// past the accepted row, so every requesting row is eventually served.
module x_rr_arbiter_hs #(
    parameter int WIDTH     = 16,
    parameter int X_WIDTH   = $clog2(WIDTH),
    parameter int MAX_BURST = 4,
    parameter int BW        = $clog2(MAX_BURST + 1)
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               enable_i,
    input  logic [WIDTH-1:0]   req_i,
    input  logic [BW-1:0]      burst_len_i,
    input  logic               ready_i,
    output logic               valid_o,
    output logic [WIDTH-1:0]   gnt_o,
    output logic [X_WIDTH-1:0] xadd_o
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [BW-1:0] ONE_B = BW'(1);
    localparam logic [BW-1:0] MAX_B = BW'(MAX_BURST);

    state_t             state;
    logic [WIDTH-1:0]   mask_ff;
    logic [BW-1:0]      burst_cnt;
    logic [BW-1:0]      blen_q;

    logic [WIDTH-1:0]   masked_req;
    logic [X_WIDTH-1:0] win_idx;
    logic [WIDTH-1:0]   hs_mask;
    logic [WIDTH-1:0]   hs_masked_req;
    logic [X_WIDTH-1:0] hs_idx;
    logic               cur_req;
    logic               handshake;
    logic               burst_more;
    logic               req_any;
    logic [BW-1:0]      blen_new;

    // Lowest set bit of a vector; returns 0 for an empty vector.
    function automatic logic [X_WIDTH-1:0] lowest_idx(input logic [WIDTH-1:0] v);
        logic [X_WIDTH-1:0] idx;
        idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = X_WIDTH'(i);
            end
        end
        return idx;
    endfunction

    // One-hot vector for a row index.
    function automatic logic [WIDTH-1:0] onehot(input logic [X_WIDTH-1:0] idx);
        return {{(WIDTH-1){1'b0}}, 1'b1} << idx;
    endfunction

    // Mask that leaves only rows above idx eligible. The shift amount is one
    // bit wider than the index so that the top row produces an all-zero mask
    // instead of wrapping the shift amount back to zero.
    function automatic logic [WIDTH-1:0] mask_after(input logic [X_WIDTH-1:0] idx);
        logic [X_WIDTH:0] sh;
        sh = {1'b0, idx} + 1'b1;
        return {WIDTH{1'b1}} << sh;
    endfunction

    // Burst length 0 means a single beat; oversize requests are clamped.
    function automatic logic [BW-1:0] clamp_len(input logic [BW-1:0] v);
        logic [BW-1:0] r;
        r = v;
        if (v == '0) begin
            r = ONE_B;
        end else if (v > MAX_B) begin
            r = MAX_B;
        end
        return r;
    endfunction

    // Winner selection for a fresh grant from IDLE and for the grant that
    // follows an accepted beat (which must already see the advanced mask).
    always_comb begin
        masked_req    = req_i & mask_ff;
        win_idx       = (|masked_req) ? lowest_idx(masked_req) : lowest_idx(req_i);
        hs_mask       = mask_after(xadd_o);
        hs_masked_req = req_i & hs_mask;
        hs_idx        = (|hs_masked_req) ? lowest_idx(hs_masked_req) : lowest_idx(req_i);
        cur_req       = req_i[xadd_o];
        handshake     = valid_o & ready_i;
        burst_more    = ((burst_cnt + 1'b1) < blen_q) & cur_req;
        req_any       = |req_i;
        blen_new      = clamp_len(burst_len_i);
    end

    // Grant FSM; every output is a register so nothing reaches the outputs
    // combinationally from req_i or ready_i.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state     <= IDLE;
            mask_ff   <= '1;
            gnt_o     <= '0;
            xadd_o    <= '0;
            valid_o   <= 1'b0;
            burst_cnt <= '0;
            blen_q    <= ONE_B;
        end else begin
            case (state)
                IDLE: begin
                    if (enable_i && req_any) begin
                        gnt_o     <= onehot(win_idx);
                        xadd_o    <= win_idx;
                        valid_o   <= 1'b1;
                        blen_q    <= blen_new;
                        burst_cnt <= '0;
                        state     <= GRANT;
                    end else begin
                        gnt_o   <= '0;
                        xadd_o  <= '0;
                        valid_o <= 1'b0;
                    end
                end
                GRANT: begin
                    if (handshake) begin
                        mask_ff <= hs_mask;
                        if (burst_more) begin
                            burst_cnt <= burst_cnt + 1'b1;
                        end else if (enable_i && req_any) begin
                            gnt_o     <= onehot(hs_idx);
                            xadd_o    <= hs_idx;
                            valid_o   <= 1'b1;
                            blen_q    <= blen_new;
                            burst_cnt <= '0;
                        end else begin
                            gnt_o   <= '0;
                            xadd_o  <= '0;
                            valid_o <= 1'b0;
                            state   <= IDLE;
                        end
                    end else if (!cur_req) begin
                        // Row withdrew before acceptance: drop the grant and
                        // keep the mask so that row keeps its turn.
                        gnt_o   <= '0;
                        xadd_o  <= '0;
                        valid_o <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    gnt_o   <= '0;
                    xadd_o  <= '0;
                    valid_o <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_x_rr_arbiter_hs.sv
// Bench for x_rr_arbiter_hs: directed scenarios followed by random traffic,
// compared cycle by cycle against a rotating-pointer reference model.
module tb_x_rr_arbiter_hs;

    localparam int W  = 8;
    localparam int MB = 4;
    localparam int XW = 3;
    localparam int BW = 3;

    logic          clk_i = 1'b0;
    logic          reset_i;
    logic          enable_i;
    logic [W-1:0]  req_i;
    logic [BW-1:0] burst_len_i;
    logic          ready_i;
    logic          valid_o;
    logic [W-1:0]  gnt_o;
    logic [XW-1:0] xadd_o;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: priority pointer plus current grant description.
    int ptr;
    bit m_valid;
    int m_row;
    int m_beats;
    int m_blen;

    x_rr_arbiter_hs #(
        .WIDTH(W), .X_WIDTH(XW), .MAX_BURST(MB), .BW(BW)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i), .enable_i(enable_i), .req_i(req_i),
        .burst_len_i(burst_len_i), .ready_i(ready_i), .valid_o(valid_o),
        .gnt_o(gnt_o), .xadd_o(xadd_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic int clamp(input int v);
        if (v == 0) return 1;
        if (v > MB) return MB;
        return v;
    endfunction

    // Search starting at the pointer and wrapping around.
    function automatic int pick(input logic [W-1:0] r, input int p);
        for (int i = 0; i < W; i++) begin
            int j;
            j = (p + i) % W;
            if (r[j]) return j;
        end
        return 0;
    endfunction

    task automatic model_reset();
        ptr     = 0;
        m_valid = 0;
        m_row   = 0;
        m_beats = 0;
        m_blen  = 1;
    endtask

    task automatic model_step();
        if (!m_valid) begin
            if (enable_i && (req_i != 0)) begin
                m_row = pick(req_i, ptr); m_valid = 1; m_beats = 0; m_blen = clamp(int'(burst_len_i));
            end
        end else if (ready_i) begin
            ptr = m_row + 1;
            if ((m_beats + 1 < m_blen) && req_i[m_row]) begin
                m_beats++;
            end else if (enable_i && (req_i != 0)) begin
                m_row = pick(req_i, ptr); m_beats = 0; m_blen = clamp(int'(burst_len_i));
            end else begin
                m_valid = 0;
            end
        end else if (!req_i[m_row]) begin
            m_valid = 0;
        end
    endtask

    task automatic check(input string tag);
        logic [W-1:0]  eg;
        logic [XW-1:0] ex;
        eg = '0;
        ex = '0;
        if (m_valid) begin
            eg[m_row] = 1'b1;
            ex = XW'(m_row);
        end
        n_checks++;
        assert (valid_o === m_valid) else begin
            n_fail++; $error("FAIL %s valid: got %0b expected %0b", tag, valid_o, m_valid);
        end
        n_checks++;
        assert (gnt_o === eg) else begin
            n_fail++; $error("FAIL %s gnt: got %0h expected %0h", tag, gnt_o, eg);
        end
        n_checks++;
        assert (xadd_o === ex) else begin
            n_fail++; $error("FAIL %s xadd: got %0d expected %0d", tag, xadd_o, ex);
        end
    endtask

    task automatic expect_x(input string tag, input int v);
        n_checks++;
        assert (valid_o === 1'b1 && xadd_o === XW'(v)) else begin
            n_fail++; $error("FAIL %s: got valid=%0b xadd=%0d expected valid=1 xadd=%0d", tag, valid_o, xadd_o, v);
        end
    endtask

    task automatic expect_idle(input string tag);
        n_checks++;
        assert (valid_o === 1'b0 && gnt_o === '0 && xadd_o === '0) else begin
            n_fail++; $error("FAIL %s: got valid=%0b gnt=%0h xadd=%0d expected all zero", tag, valid_o, gnt_o, xadd_o);
        end
    endtask

    task automatic cycle(input string tag);
        model_step();
        @(posedge clk_i);
        #1;
        check(tag);
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic do_reset(input string tag);
        #2 reset_i = 1'b1;
        #1;
        model_reset();
        expect_idle(tag);
        check(tag);
        #2 reset_i = 1'b0;
    endtask

    initial begin
        int seq1[6] = '{1, 4, 7, 1, 4, 7};
        int seq3[7] = '{0, 0, 0, 5, 5, 5, 0};
        reset_i = 1'b1; enable_i = 1'b0; req_i = '0; ready_i = 1'b0; burst_len_i = 3'd1;
        model_reset();
        #12;
        expect_idle("reset_state");
        check("reset_state");
        @(negedge clk_i);
        reset_i = 1'b0;

        // Single-beat rotation with constant ready.
        enable_i = 1'b1; req_i = 8'b1001_0010; burst_len_i = 3'd1; ready_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cycle("rotate");
            expect_x("rotate_seq", seq1[i]);
        end
        req_i = '0;
        cycle("drain"); cycle("drain");

        // Held grant under back-pressure, then re-grant of the sole requester.
        req_i = 8'b0000_0100; ready_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cycle("hold");
            expect_x("hold_row2", 2);
        end
        ready_i = 1'b1;
        cycle("regrant");
        expect_x("regrant_row2", 2);
        req_i = '0;
        cycle("drain"); cycle("drain");

        // Burst hold of three beats alternating between rows 0 and 5.
        do_reset("reset_before_burst");
        req_i = 8'b0010_0001; burst_len_i = 3'd3; ready_i = 1'b1;
        for (int i = 0; i < 7; i++) begin
            cycle("burst3");
            expect_x("burst3_seq", seq3[i]);
        end
        burst_len_i = 3'd0;
        for (int i = 0; i < 6; i++) cycle("burst0");
        burst_len_i = 3'd7;
        for (int i = 0; i < 12; i++) cycle("burst7");
        req_i = '0;
        cycle("drain"); cycle("drain");

        // Revocation keeps the mask: row 3 wins again when re-requested.
        do_reset("reset_before_revoke");
        burst_len_i = 3'd1; ready_i = 1'b0; req_i = 8'h08;
        cycle("revoke_grant");
        expect_x("revoke_grant_row3", 3);
        req_i = '0;
        cycle("revoke_drop");
        expect_idle("revoke_drop");
        req_i = 8'h88;
        cycle("revoke_rereq");
        expect_x("revoke_rereq_row3", 3);
        req_i = '0; ready_i = 1'b1;
        cycle("drain"); cycle("drain");

        // Enable low lets the current beat finish but blocks new grants.
        do_reset("reset_before_enable");
        req_i = 8'h40; ready_i = 1'b0;
        cycle("en_grant6");
        expect_x("en_grant6", 6);
        enable_i = 1'b0; req_i = 8'h81; ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle("en_blocked");
            expect_idle("en_blocked");
        end
        enable_i = 1'b1;
        cycle("en_resume");
        expect_x("en_resume_row7", 7);

        // Asynchronous reset in the middle of a burst on row 5.
        do_reset("reset_before_async");
        req_i = 8'h20; burst_len_i = 3'd4; ready_i = 1'b1;
        cycle("async_grant5");
        expect_x("async_grant5", 5);
        cycle("async_beat");
        #2 reset_i = 1'b1;
        #1;
        model_reset();
        expect_idle("async_reset_now");
        req_i = 8'hA0;
        @(negedge clk_i);
        reset_i = 1'b0;
        cycle("async_release");
        expect_x("async_release_row5", 5);

        // Random traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 3) == 0) req_i = W'($urandom);
            enable_i    = ($urandom_range(0, 7) != 0);
            ready_i     = $urandom_range(0, 1) != 0;
            burst_len_i = BW'($urandom_range(0, 7));
            cycle("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
